// File: rtl/counter_pkg.sv
// Shared definitions for the counter / countdown_timer timing blocks.
package counter_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;

  // Countdown timer control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } cd_state_t;

endpackage : counter_pkg

// File: rtl/countdown_timer.sv
// Loadable down-counter with valid/ready start, pause, abort and optional auto-reload.
module countdown_timer
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH       = DEFAULT_WIDTH,
  parameter bit          AUTO_RELOAD = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_value,
  output logic             load_ready,
  input  logic             en,
  input  logic             abort,
  output logic [WIDTH-1:0] cnt,
  output logic             busy,
  output logic             done
);

  cd_state_t        state;
  cd_state_t        state_next;
  logic [WIDTH-1:0] cnt_next;
  logic [WIDTH-1:0] reload_reg;
  logic [WIDTH-1:0] reload_next;

  // Ready is a pure state decode, forced low while reset is asserted.
  assign load_ready = (state == IDLE) && !rst;

  // Next-state and datapath; abort overrides everything, including a same-cycle load.
  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    reload_next = reload_reg;
    if (abort) begin
      state_next = IDLE;
      cnt_next   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (load_valid && load_ready) begin
            cnt_next    = load_value;
            reload_next = load_value;
            if (load_value == '0) begin
              state_next = DONE;
            end else if (en) begin
              state_next = RUN;
            end else begin
              state_next = HOLD;
            end
          end
        end
        RUN: begin
          if (!en) begin
            state_next = HOLD;
          end else begin
            cnt_next = cnt - WIDTH'(1);
            // The 1->0 step always leaves RUN, so the count never wraps.
            if (cnt == WIDTH'(1)) begin
              state_next = DONE;
            end
          end
        end
        HOLD: begin
          if (en) begin
            state_next = RUN;
          end
        end
        DONE: begin
          if (AUTO_RELOAD && (reload_reg != '0)) begin
            cnt_next   = reload_reg;
            state_next = en ? RUN : HOLD;
          end else begin
            state_next = IDLE;
          end
        end
        default: begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      endcase
    end
  end

  // State, count and registered status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      reload_reg <= '0;
      done       <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      reload_reg <= reload_next;
      done       <= (state_next == DONE);
      busy       <= (state_next != IDLE);
    end
  end

endmodule : countdown_timer

// File: tb/tb_countdown_timer.sv
// Self-checking bench: one-shot and auto-reload instances driven in lockstep.
module tb_countdown_timer;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         load_valid;
  logic [W-1:0] load_value;
  logic         en;
  logic         abort;

  logic         rdy0, busy0, done0;
  logic [W-1:0] cnt0;
  logic         rdy1, busy1, done1;
  logic [W-1:0] cnt1;

  int errors = 0;
  int checks = 0;

  // Reference model state: 0 idle, 1 run, 2 hold, 3 done.
  int m_st  [2];
  int m_cnt [2];
  int m_rl  [2];

  logic [13:0] sbq [$];

  always #5 clk = ~clk;

  countdown_timer #(.WIDTH(W), .AUTO_RELOAD(1'b0)) dut0 (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_value(load_value),
    .load_ready(rdy0), .en(en), .abort(abort), .cnt(cnt0), .busy(busy0), .done(done0)
  );

  countdown_timer #(.WIDTH(W), .AUTO_RELOAD(1'b1)) dut1 (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_value(load_value),
    .load_ready(rdy1), .en(en), .abort(abort), .cnt(cnt1), .busy(busy1), .done(done1)
  );

  function automatic logic [13:0] dut_vec();
    return {cnt0, done0, busy0, rdy0, cnt1, done1, busy1, rdy1};
  endfunction

  function automatic logic [6:0] model_out(int i);
    logic [3:0] c;
    c = 4'(m_cnt[i]);
    return {c, m_st[i] == 3, m_st[i] != 0, m_st[i] == 0};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_st[i] = 0; m_cnt[i] = 0; m_rl[i] = 0;
    end
    sbq.delete();
  endtask

  // Advance the model by one edge with current inputs, queue its outputs, then clock the DUTs.
  task automatic step();
    for (int i = 0; i < 2; i++) begin
      if (abort) begin
        m_st[i] = 0; m_cnt[i] = 0;
      end else begin
        case (m_st[i])
          0: if (load_valid) begin
               m_cnt[i] = int'(load_value); m_rl[i] = int'(load_value);
               m_st[i]  = (load_value == 0) ? 3 : (en ? 1 : 2);
             end
          1: if (!en) m_st[i] = 2;
             else begin
               m_cnt[i] = m_cnt[i] - 1;
               if (m_cnt[i] == 0) m_st[i] = 3;
             end
          2: if (en) m_st[i] = 1;
          default: if (i == 1 && m_rl[i] != 0) begin
                     m_cnt[i] = m_rl[i]; m_st[i] = en ? 1 : 2;
                   end else m_st[i] = 0;
        endcase
      end
    end
    sbq.push_back({model_out(0), model_out(1)});
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    load_valid = 1'b0; load_value = '0; en = 1'b0; abort = 1'b0;
  endtask

  task automatic test_reset();
    logic [13:0] e;
    rst = 1'b1; quiet();
    @(posedge clk); #1;
    checks++;
    if (dut_vec() !== 14'h0) begin
      errors++; $display("FAIL reset_state: got %h expected %h", dut_vec(), 14'h0);
    end
    rst = 1'b0; #1;
    model_reset();
    checks++;
    if ({rdy0, rdy1} !== 2'b11) begin
      errors++; $display("FAIL reset_release_ready: got %b expected 11", {rdy0, rdy1});
    end
    for (int c = 0; c < 4; c++) begin
      load_valid = (c == 0); load_value = 4'd9; en = 1'b1;
      step();
      e = sbq.pop_front(); checks++;
      if (dut_vec() !== e) begin
        errors++; $display("FAIL reset_precount c=%0d: got %h expected %h", c, dut_vec(), e);
      end
    end
    rst = 1'b1; #2;
    checks++;
    if ({cnt0, busy0, done0, cnt1, busy1, done1} !== 10'h0) begin
      errors++; $display("FAIL reset_async: got %h expected 0", {cnt0, busy0, done0, cnt1, busy1, done1});
    end
    @(posedge clk); #1;
    rst = 1'b0; #1;
    model_reset(); quiet();
    checks++;
    if ({rdy0, busy0, rdy1, busy1} !== 4'b1010) begin
      errors++; $display("FAIL reset_idle_after: got %b expected 1010", {rdy0, busy0, rdy1, busy1});
    end
  endtask

  task automatic test_one_shot();
    logic [13:0] e;
    logic [3:0]  exp_cnt [6];
    exp_cnt = '{4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0};
    quiet(); abort = 1'b1; step(); void'(sbq.pop_front());
    for (int c = 0; c < 7; c++) begin
      quiet(); en = 1'b1; load_valid = (c == 0); load_value = 4'd5;
      step();
      e = sbq.pop_front(); checks++;
      if (dut_vec() !== e) begin
        errors++; $display("FAIL one_shot c=%0d: got %h expected %h", c, dut_vec(), e);
      end
      if (c < 6) begin
        checks++;
        if ({cnt0, done0} !== {exp_cnt[c], c == 5}) begin
          errors++; $display("FAIL one_shot_seq c=%0d: got cnt=%0d done=%b expected cnt=%0d done=%b",
                             c, cnt0, done0, exp_cnt[c], c == 5);
        end
      end else begin
        checks++;
        if ({rdy0, busy0, done0} !== 3'b100) begin
          errors++; $display("FAIL one_shot_idle: got %b expected 100", {rdy0, busy0, done0});
        end
      end
    end
  endtask

  task automatic test_pause();
    logic [13:0] e;
    int done_at;
    done_at = -1;
    quiet(); abort = 1'b1; step(); void'(sbq.pop_front());
    for (int c = 0; c < 12; c++) begin
      quiet(); load_valid = (c == 0); load_value = 4'd6;
      en = !(c == 3 || c == 4);
      step();
      e = sbq.pop_front(); checks++;
      if (dut_vec() !== e) begin
        errors++; $display("FAIL pause c=%0d: got %h expected %h", c, dut_vec(), e);
      end
      if (done0 && done_at < 0) done_at = c;
    end
    // Unpaused, done would follow the load by 6 edges; the pause costs 3.
    checks++;
    if (done_at != 9) begin
      errors++; $display("FAIL pause_done_delay: got %0d expected 9", done_at);
    end
  endtask

  task automatic test_edges();
    logic [13:0] e;
    int done_at;
    int wraps;
    quiet(); abort = 1'b1; step(); void'(sbq.pop_front());
    for (int c = 0; c < 2; c++) begin
      quiet(); en = 1'b1; load_valid = (c == 0); load_value = 4'd0;
      step();
      e = sbq.pop_front(); checks++;
      if (dut_vec() !== e) begin
        errors++; $display("FAIL zero_load c=%0d: got %h expected %h", c, dut_vec(), e);
      end
      if (c == 0) begin
        checks++;
        if ({done0, cnt0, done1, cnt1} !== 10'b1_0000_1_0000) begin
          errors++; $display("FAIL zero_load_done: got %b expected 1000010000", {done0, cnt0, done1, cnt1});
        end
      end
    end
    done_at = -1; wraps = 0;
    for (int c = 0; c < 18; c++) begin
      quiet(); en = 1'b1; load_valid = (c == 0); load_value = 4'd15;
      step();
      e = sbq.pop_front(); checks++;
      if (dut_vec() !== e) begin
        errors++; $display("FAIL max_load c=%0d: got %h expected %h", c, dut_vec(), e);
      end
      if (done0 && done_at < 0) done_at = c;
      if (c > 0 && cnt0 == 4'd15) wraps++;
    end
    checks++;
    if (done_at != 15 || wraps != 0) begin
      errors++; $display("FAIL max_load_span: got done_at=%0d wraps=%0d expected 15 and 0", done_at, wraps);
    end
  endtask

  task automatic test_auto_reload();
    logic [13:0] e;
    logic [3:0]  exp_cnt [8];
    exp_cnt = '{4'd3, 4'd2, 4'd1, 4'd0, 4'd3, 4'd2, 4'd1, 4'd0};
    quiet(); abort = 1'b1; step(); void'(sbq.pop_front());
    for (int c = 0; c < 13; c++) begin
      quiet(); en = 1'b1; load_valid = (c == 0); load_value = 4'd3;
      abort = (c == 12);
      step();
      e = sbq.pop_front(); checks++;
      if (dut_vec() !== e) begin
        errors++; $display("FAIL auto_reload c=%0d: got %h expected %h", c, dut_vec(), e);
      end
      if (c < 8) begin
        checks++;
        if ({cnt1, done1} !== {exp_cnt[c], (c % 4) == 3}) begin
          errors++; $display("FAIL auto_reload_seq c=%0d: got cnt=%0d done=%b expected cnt=%0d done=%b",
                             c, cnt1, done1, exp_cnt[c], (c % 4) == 3);
        end
      end
      if (c == 11) begin
        checks++;
        if (done1 !== 1'b1) begin
          errors++; $display("FAIL auto_reload_third_done: got %b expected 1", done1);
        end
      end
    end
    checks++;
    if ({cnt1, busy1, done1, rdy1} !== 7'b0000_001) begin
      errors++; $display("FAIL abort_in_reload: got %b expected 0000001", {cnt1, busy1, done1, rdy1});
    end
  endtask

  task automatic test_handshake();
    logic [13:0] e;
    quiet(); abort = 1'b1; step(); void'(sbq.pop_front());
    for (int c = 0; c < 9; c++) begin
      quiet(); en = 1'b1; load_valid = 1'b1; load_value = 4'((c * 3 + 5) % 16);
      step();
      e = sbq.pop_front(); checks++;
      if (dut_vec() !== e) begin
        errors++; $display("FAIL hold_valid c=%0d: got %h expected %h", c, dut_vec(), e);
      end
      if (c >= 1 && c <= 5) begin
        checks++;
        if (cnt0 !== 4'(5 - c)) begin
          errors++; $display("FAIL busy_no_capture c=%0d: got %0d expected %0d", c, cnt0, 5 - c);
        end
      end
      if (c == 7) begin
        checks++;
        if ({cnt0, busy0} !== {4'd10, 1'b1}) begin
          errors++; $display("FAIL idle_capture: got cnt=%0d busy=%b expected cnt=10 busy=1", cnt0, busy0);
        end
      end
    end
    quiet(); abort = 1'b1; step(); void'(sbq.pop_front());
    quiet(); abort = 1'b1; load_valid = 1'b1; load_value = 4'd9; en = 1'b1;
    step();
    e = sbq.pop_front(); checks++;
    if (dut_vec() !== e) begin
      errors++; $display("FAIL abort_with_load: got %h expected %h", dut_vec(), e);
    end
    checks++;
    if ({cnt0, busy0, rdy0, cnt1, busy1, rdy1} !== 12'b0000_0_1_0000_0_1) begin
      errors++; $display("FAIL abort_rejects_load: got %b expected 000001000001",
                         {cnt0, busy0, rdy0, cnt1, busy1, rdy1});
    end
    quiet();
  endtask

  initial begin
    test_reset();
    test_one_shot();
    test_pause();
    test_edges();
    test_auto_reload();
    test_handshake();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_countdown_timer
